// File: rtl/lieat_exu_wbu_arb.sv
// -----------------------------------------------------------------------------
// lieat_exu_wbu_arb
//
// Writeback arbiter. It merges NCH execution-unit writeback channels into a
// single registered writeback port that feeds the regfile/commit stage.
//
// Arbitration is selected by RR_MODE:
//   0 : fixed priority (lowest index wins). Each channel has an 8-bit wait
//       counter. A channel that has waited STARVE_MAX or more cycles is
//       promoted above all non-promoted channels.
//   1 : round-robin. The search starts at a pointer and wraps. After a grant
//       to channel k the pointer moves to k+1.
//
// Handshake semantics (valid/ready, both directions):
//   A transfer happens on a cycle where valid and ready are both high.
//   ready never depends on a transfer having already happened. A producer
//   that sees valid=1 and ready=0 has made no commitment and may change or
//   withdraw its payload. Input-side ready is one-hot or zero, and it is
//   asserted only on a valid channel. The output register accepts a new
//   entry when it is empty or being drained in the same cycle, so a stream
//   can move one entry per cycle.
//
// Ports:
//   clock, reset  : clock; synchronous active-high reset
//   wbck_i_valid  : [NCH]        per-channel request
//   wbck_i_ready  : [NCH]        per-channel grant (one-hot or zero)
//   wbck_i_pc     : [NCH*XLEN]   packed pc, channel k at [k*XLEN +: XLEN]
//   wbck_i_en     : [NCH]        per-channel regfile write enable
//   wbck_i_rd     : [NCH*RIDX]   packed destination register
//   wbck_i_data   : [NCH*XLEN]   packed result
//   wbck_i_flag   : [NCH]        per-channel sideband bit, passed through
//   wbck_o_valid  : registered output valid
//   wbck_o_ready  : downstream accept
//   wbck_o_op     : [NCH] one-hot source channel of the held entry
//   wbck_o_pc/en/rd/data/flag : payload of the held entry
// -----------------------------------------------------------------------------
module lieat_exu_wbu_arb #(
  parameter int NCH        = 5,
  parameter int XLEN       = 32,
  parameter int RIDX       = 5,
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH-1:0]        wbck_i_valid,
  output logic [NCH-1:0]        wbck_i_ready,
  input  logic [NCH*XLEN-1:0]   wbck_i_pc,
  input  logic [NCH-1:0]        wbck_i_en,
  input  logic [NCH*RIDX-1:0]   wbck_i_rd,
  input  logic [NCH*XLEN-1:0]   wbck_i_data,
  input  logic [NCH-1:0]        wbck_i_flag,
  output logic                  wbck_o_valid,
  input  logic                  wbck_o_ready,
  output logic [NCH-1:0]        wbck_o_op,
  output logic [XLEN-1:0]       wbck_o_pc,
  output logic                  wbck_o_en,
  output logic [RIDX-1:0]       wbck_o_rd,
  output logic [XLEN-1:0]       wbck_o_data,
  output logic                  wbck_o_flag
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Output register
  logic            r_valid;
  logic [NCH-1:0]  r_op;
  logic [XLEN-1:0] r_pc;
  logic            r_en;
  logic [RIDX-1:0] r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_flag;

  logic            w_load_ok;
  logic [NCH-1:0]  w_pick;    // arbiter choice before load_ok gating
  logic [NCH-1:0]  w_grant;
  logic            w_any_grant;

  // The output register can take a new entry when it is empty or when its
  // current entry leaves this cycle.
  assign w_load_ok   = ~r_valid | wbck_o_ready;
  assign w_grant     = w_load_ok ? w_pick : '0;
  assign w_any_grant = |w_grant;
  assign wbck_i_ready = w_grant;

  generate
    if (RR_MODE == 0) begin : g_fixed
      logic [7:0]     r_cnt [NCH];
      logic [NCH-1:0] w_promo;
      logic           w_found;

      always_comb begin
        w_promo = '0;
        for (int k = 0; k < NCH; k++) begin
          w_promo[k] = wbck_i_valid[k] & (r_cnt[k] >= 8'(STARVE_MAX));
        end
      end

      // Promoted channels first, then plain fixed priority.
      always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          if (!w_found && w_promo[k]) begin
            w_pick[k] = 1'b1;
            w_found   = 1'b1;
          end
        end
        for (int k = 0; k < NCH; k++) begin
          if (!w_found && wbck_i_valid[k]) begin
            w_pick[k] = 1'b1;
            w_found   = 1'b1;
          end
        end
      end

      // Wait counters advance only while the output stage is accepting. A
      // stall is not the losing channel's fault, so it does not count.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int k = 0; k < NCH; k++) r_cnt[k] <= 8'd0;
        end else if (w_load_ok) begin
          for (int k = 0; k < NCH; k++) begin
            if (!wbck_i_valid[k] || w_grant[k]) begin
              r_cnt[k] <= 8'd0;
            end else if (r_cnt[k] != 8'hFF) begin
              r_cnt[k] <= r_cnt[k] + 8'd1;
            end
          end
        end
      end
    end else begin : g_rr
      logic [PW-1:0] r_ptr;
      logic [PW-1:0] w_nxt_ptr;
      logic          w_found;

      // Two passes: channels at or above the pointer, then the wrapped
      // channels below it. The first valid channel found wins.
      always_comb begin
        w_pick    = '0;
        w_nxt_ptr = r_ptr;
        w_found   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          if (!w_found && wbck_i_valid[k] && (k >= int'(r_ptr))) begin
            w_pick[k] = 1'b1;
            w_found   = 1'b1;
            w_nxt_ptr = (k == NCH - 1) ? '0 : PW'(k + 1);
          end
        end
        for (int k = 0; k < NCH; k++) begin
          if (!w_found && wbck_i_valid[k] && (k < int'(r_ptr))) begin
            w_pick[k] = 1'b1;
            w_found   = 1'b1;
            w_nxt_ptr = (k == NCH - 1) ? '0 : PW'(k + 1);
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          r_ptr <= '0;
        end else if (w_any_grant) begin
          r_ptr <= w_nxt_ptr;
        end
      end
    end
  endgenerate

  // One-hot payload mux. The grant is one-hot or zero, so an OR reduction
  // is enough.
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_data;
  logic [RIDX-1:0] w_rd;
  logic            w_en;
  logic            w_flag;

  always_comb begin
    w_pc   = '0;
    w_data = '0;
    w_rd   = '0;
    w_en   = 1'b0;
    w_flag = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      w_pc   = w_pc   | ({XLEN{w_grant[k]}} & wbck_i_pc[k*XLEN +: XLEN]);
      w_data = w_data | ({XLEN{w_grant[k]}} & wbck_i_data[k*XLEN +: XLEN]);
      w_rd   = w_rd   | ({RIDX{w_grant[k]}} & wbck_i_rd[k*RIDX +: RIDX]);
      w_en   = w_en   | (w_grant[k] & wbck_i_en[k]);
      w_flag = w_flag | (w_grant[k] & wbck_i_flag[k]);
    end
  end

  // When the entry drains with no new grant, only valid drops. The payload
  // registers keep their old contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_pc    <= '0;
      r_en    <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      r_flag  <= 1'b0;
    end else if (w_load_ok) begin
      if (w_any_grant) begin
        r_valid <= 1'b1;
        r_op    <= w_grant;
        r_pc    <= w_pc;
        r_en    <= w_en;
        r_rd    <= w_rd;
        r_data  <= w_data;
        r_flag  <= w_flag;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign wbck_o_valid = r_valid;
  assign wbck_o_op    = r_op;
  assign wbck_o_pc    = r_pc;
  assign wbck_o_en    = r_en;
  assign wbck_o_rd    = r_rd;
  assign wbck_o_data  = r_data;
  assign wbck_o_flag  = r_flag;

endmodule

// File: tb/tb_lieat_exu_wbu_arb.sv
// -----------------------------------------------------------------------------
// Bench for lieat_exu_wbu_arb. Two instances share one stimulus: u_fix uses
// fixed priority with promotion, and u_rr uses round-robin. Expected output
// entries are queued when a grant is expected. Per-DUT monitors pop them
// whenever an entry leaves the output register.
// -----------------------------------------------------------------------------
module tb_lieat_exu_wbu_arb;
  localparam int NCH  = 5;
  localparam int XLEN = 32;
  localparam int RIDX = 5;
  localparam int EW   = NCH + 2 + RIDX + 2 * XLEN;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- shared stimulus ----------------
  logic [NCH-1:0]      in_valid, in_en, in_flag;
  logic [NCH*XLEN-1:0] in_pc, in_data;
  logic [NCH*RIDX-1:0] in_rd;
  logic                o_ready;

  // ---------------- DUT outputs ----------------
  logic [NCH-1:0]  f_i_ready, f_op, r_i_ready, r_op;
  logic            f_valid, f_en, f_flag, r_valid, r_en, r_flag;
  logic [XLEN-1:0] f_pc, f_data, r_pc, r_data;
  logic [RIDX-1:0] f_rd, r_rd;

  lieat_exu_wbu_arb #(
    .NCH(NCH), .XLEN(XLEN), .RIDX(RIDX), .RR_MODE(0), .STARVE_MAX(8)
  ) u_fix (
    .clock(clock), .reset(reset),
    .wbck_i_valid(in_valid), .wbck_i_ready(f_i_ready),
    .wbck_i_pc(in_pc), .wbck_i_en(in_en), .wbck_i_rd(in_rd),
    .wbck_i_data(in_data), .wbck_i_flag(in_flag),
    .wbck_o_valid(f_valid), .wbck_o_ready(o_ready), .wbck_o_op(f_op),
    .wbck_o_pc(f_pc), .wbck_o_en(f_en), .wbck_o_rd(f_rd),
    .wbck_o_data(f_data), .wbck_o_flag(f_flag)
  );

  lieat_exu_wbu_arb #(
    .NCH(NCH), .XLEN(XLEN), .RIDX(RIDX), .RR_MODE(1), .STARVE_MAX(8)
  ) u_rr (
    .clock(clock), .reset(reset),
    .wbck_i_valid(in_valid), .wbck_i_ready(r_i_ready),
    .wbck_i_pc(in_pc), .wbck_i_en(in_en), .wbck_i_rd(in_rd),
    .wbck_i_data(in_data), .wbck_i_flag(in_flag),
    .wbck_o_valid(r_valid), .wbck_o_ready(o_ready), .wbck_o_op(r_op),
    .wbck_o_pc(r_pc), .wbck_o_en(r_en), .wbck_o_rd(r_rd),
    .wbck_o_data(r_data), .wbck_o_flag(r_flag)
  );

  wire [EW-1:0] f_entry = {f_op, f_en, f_flag, f_rd, f_pc, f_data};
  wire [EW-1:0] r_entry = {r_op, r_en, r_flag, r_rd, r_pc, r_data};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_fix_q[$];
  logic [EW-1:0] exp_rr_q[$];
  bit chk_fix = 1'b0;
  bit chk_rr  = 1'b0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // An entry leaves the output register when valid & ready.
  always @(negedge clock) begin
    if (chk_fix && !reset && f_valid && o_ready) begin
      if (exp_fix_q.size() == 0) check("fix_unexpected_op", f_op, 0);
      else check("fix_out", f_entry, exp_fix_q.pop_front());
    end
  end

  always @(negedge clock) begin
    if (chk_rr && !reset && r_valid && o_ready) begin
      if (exp_rr_q.size() == 0) check("rr_unexpected_op", r_op, 0);
      else check("rr_out", r_entry, exp_rr_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_en    = '0;
    in_flag  = '0;
    in_pc    = '0;
    in_data  = '0;
    in_rd    = '0;
  endtask

  task automatic set_ch(input int k, input logic [XLEN-1:0] pc,
                        input logic [RIDX-1:0] rd, input logic [XLEN-1:0] data,
                        input logic en, input logic flag);
    in_valid[k]             = 1'b1;
    in_pc[k*XLEN +: XLEN]   = pc;
    in_rd[k*RIDX +: RIDX]   = rd;
    in_data[k*XLEN +: XLEN] = data;
    in_en[k]                = en;
    in_flag[k]              = flag;
  endtask

  task automatic set_rand(input int k);
    set_ch(k, $urandom(), RIDX'($urandom_range(0, 31)), $urandom(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Expected entry for a grant to channel k, built from the bench's own
  // driven inputs.
  function automatic logic [EW-1:0] exp_entry(input int k);
    logic [NCH-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    return {oh, in_en[k], in_flag[k], in_rd[k*RIDX +: RIDX],
            in_pc[k*XLEN +: XLEN], in_data[k*XLEN +: XLEN]};
  endfunction

  function automatic logic [NCH-1:0] onehot(input int k);
    logic [NCH-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    return oh;
  endfunction

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_fix_q.size() + exp_rr_q.size()) != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(tag, exp_fix_q.size() + exp_rr_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int seq_fix[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 0};
  logic [EW-1:0] held;

  initial begin
    clear_in();
    o_ready = 1'b1;
    reset   = 1'b1;
    repeat (2) step();
    @(negedge clock);
    check("rst_fix_outs", {f_valid, f_entry}, 0);
    check("rst_rr_outs", {r_valid, r_entry}, 0);
    step();
    reset = 1'b0;

    // Single channel: ch2 payload with one-cycle latency.
    chk_fix = 1'b1;
    chk_rr  = 1'b1;
    step();
    set_ch(2, 32'h8000_0010, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1);
    exp_fix_q.push_back(exp_entry(2));
    exp_rr_q.push_back(exp_entry(2));
    @(negedge clock);
    check("ch2_grant_fix", f_i_ready, 5'b00100);
    check("ch2_grant_rr", r_i_ready, 5'b00100);
    check("ch2_not_yet_valid", f_valid, 0);
    step();
    clear_in();
    @(negedge clock);
    check("ch2_valid_fix", f_valid, 1);
    check("ch2_exact_fix", {f_op, f_pc, f_rd, f_data, f_en, f_flag},
          {5'b00100, 32'h8000_0010, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1});
    wait_drain("drain_ch2");

    // Backpressure: ch3 entry held for 3 cycles while ch0 requests.
    step();
    set_rand(3);
    held = exp_entry(3);
    exp_fix_q.push_back(held);
    exp_rr_q.push_back(held);
    for (int i = 0; i < 3; i++) begin
      step();
      clear_in();
      set_ch(0, 32'h0000_1000, 5'd3, 32'h1234_5678, 1'b1, 1'b0);
      o_ready = 1'b0;
      @(negedge clock);
      check("hold_no_grant_fix", f_i_ready, 0);
      check("hold_no_grant_rr", r_i_ready, 0);
      check("hold_outs_fix", {f_valid, f_entry}, {1'b1, held});
      check("hold_outs_rr", {r_valid, r_entry}, {1'b1, held});
    end
    step();
    o_ready = 1'b1;
    exp_fix_q.push_back(exp_entry(0));
    exp_rr_q.push_back(exp_entry(0));
    @(negedge clock);
    check("release_grant_fix", f_i_ready, 5'b00001);
    check("release_grant_rr", r_i_ready, 5'b00001);
    step();
    clear_in();
    @(negedge clock);
    check("no_bubble_fix", f_valid, 1);
    check("no_bubble_rr", r_valid, 1);
    wait_drain("drain_hold");

    // Commit-only slot: ch1 with en=0.
    step();
    set_ch(1, $urandom(), 5'd9, $urandom(), 1'b0, 1'b0);
    exp_fix_q.push_back(exp_entry(1));
    exp_rr_q.push_back(exp_entry(1));
    step();
    clear_in();
    @(negedge clock);
    check("en0_valid_en_fix", {f_valid, f_en}, 2'b10);
    check("en0_valid_en_rr", {r_valid, r_en}, 2'b10);
    wait_drain("drain_en0");

    // Reset mid-transfer. ch0, ch2 and ch4 are busy beforehand, so the fixed
    // counters and the round-robin pointer both hold non-zero state.
    chk_fix = 1'b0;
    chk_rr  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      clear_in();
      set_rand(0);
      set_rand(2);
      set_rand(4);
    end
    @(negedge clock);
    check("pre_rst_valid_fix", f_valid, 1);
    step();
    reset = 1'b1;
    step();
    clear_in();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_fix_outs", {f_valid, f_entry}, 0);
    check("midrst_rr_outs", {r_valid, r_entry}, 0);

    // Fixed-priority starvation, starting from cleared counters.
    chk_fix = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      for (int k = 0; k < NCH; k++) set_rand(k);
      exp_fix_q.push_back(exp_entry(seq_fix[i]));
      @(negedge clock);
      check($sformatf("starve_grant_%0d", i), f_i_ready, onehot(seq_fix[i]));
    end
    step();
    clear_in();
    wait_drain("drain_starve");
    chk_fix = 1'b0;

    // Round-robin from a freshly reset pointer: ch1 and ch3 alternate.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_rr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      clear_in();
      set_rand(1);
      set_rand(3);
      exp_rr_q.push_back(exp_entry((i % 2 == 0) ? 1 : 3));
      @(negedge clock);
      check($sformatf("rr_grant_%0d", i), r_i_ready,
            onehot((i % 2 == 0) ? 1 : 3));
      if (i > 0) check($sformatf("rr_valid_%0d", i), r_valid, 1);
    end
    step();
    clear_in();
    wait_drain("drain_rr");
    chk_rr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
